// File: rtl/ham_dec.sv
// ham_dec: dual-port pipelined SECDED Hamming decoder.
// Each port checks a stored codeword, corrects single-bit errors, flags
// double-bit errors, and keeps saturating event counters. A port is a
// 2-stage valid/ready pipeline. Stage 1 registers the word with its
// syndrome and overall parity. Stage 2 registers the classified result.

module ham_dec_port #(
   parameter int DATA_WIDTH   = 32,
   parameter int ENCODED_WORD = 38,
   parameter int SYN_W        = 6,
   parameter int CNT_W        = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr_cnt,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic [ENCODED_WORD+1:1] s_word,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic [DATA_WIDTH-1:0]   data,
   output logic                    sec,
   output logic                    ded,
   output logic [SYN_W-1:0]        syndrome,
   output logic [CNT_W-1:0]        sec_cnt,
   output logic [CNT_W-1:0]        ded_cnt
);

   // Highest syndrome value that names a real bit position.
   localparam logic [SYN_W:0] MAX_POS = (SYN_W+1)'(ENCODED_WORD);

   // XOR of the indices of all set bits; zero for a clean word.
   function automatic logic [SYN_W-1:0] calc_syndrome(input logic [ENCODED_WORD:1] w);
      logic [SYN_W-1:0]    s;
      logic [ENCODED_WORD:1] rem;
      s   = '0;
      rem = w;
      for (int k = 1; k <= ENCODED_WORD; k++) begin
         s   = s ^ (rem[1] ? SYN_W'(k) : {SYN_W{1'b0}});
         rem = rem >> 1;
      end
      return s;
   endfunction

   // Overall parity across the whole stored word, including its parity bit.
   function automatic logic calc_parity(input logic [ENCODED_WORD+1:1] w);
      return ^w;
   endfunction

   // True for check-bit positions (1, 2, 4, 8, ...).
   function automatic logic is_pow2(input int k);
      return (k & (k - 32'sd1)) == 32'sd0;
   endfunction

   // Gather data bits from the non-power-of-2 positions, lowest position
   // first. Bits are shifted in from the top so the first one lands in
   // bit 0 once all DATA_WIDTH of them have been collected.
   function automatic logic [DATA_WIDTH-1:0] extract(input logic [ENCODED_WORD:1] w);
      logic [DATA_WIDTH-1:0] d;
      logic [ENCODED_WORD:1] rem;
      d   = '0;
      rem = w;
      for (int k = 1; k <= ENCODED_WORD; k++) begin
         if (!is_pow2(k)) begin
            d = {rem[1], d[DATA_WIDTH-1:1]};
         end else begin
            d = d;
         end
         rem = rem >> 1;
      end
      return d;
   endfunction

   logic                    s1_valid;
   logic [ENCODED_WORD:1]   s1_word;
   logic [SYN_W-1:0]        s1_syn;
   logic                    s1_par;

   logic                    s2_adv;
   logic                    accept;
   logic                    s2_load;

   logic                    syn_zero;
   logic                    in_range;
   logic [ENCODED_WORD:1]   flip_mask;
   logic [DATA_WIDTH-1:0]   next_data;
   logic                    next_sec;
   logic                    next_ded;

   // Handshake: stage 2 moves when empty or drained; stage 1 accepts when it can move on.
   always_comb begin
      s2_adv  = !m_valid || m_ready;
      s_ready = !s1_valid || s2_adv;
      accept  = s_valid && s_ready;
      s2_load = s1_valid && s2_adv;
   end

   // Classify the stage-1 word and form the corrected or raw data.
   always_comb begin
      syn_zero  = (s1_syn == {SYN_W{1'b0}});
      in_range  = ({1'b0, s1_syn} <= MAX_POS);
      flip_mask = ENCODED_WORD'(1) << (s1_syn - SYN_W'(1));
      next_data = extract(s1_word);
      next_sec  = 1'b0;
      next_ded  = 1'b0;
      case ({syn_zero, s1_par})
         2'b10: begin
            next_sec = 1'b0;
            next_ded = 1'b0;
         end
         2'b11: begin
            // Only the overall-parity bit flipped; data bits are intact.
            next_sec = 1'b1;
         end
         2'b00: begin
            // Nonzero syndrome with even parity: two bits flipped.
            next_ded = 1'b1;
         end
         2'b01: begin
            if (in_range) begin
               next_data = extract(s1_word ^ flip_mask);
               next_sec  = 1'b1;
            end else begin
               // Syndrome points past the word: more than one error.
               next_ded  = 1'b1;
            end
         end
         default: begin
            next_ded = 1'b1;
         end
      endcase
   end

   // Stage 1: capture the accepted word with its syndrome and overall parity.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_word  <= '0;
         s1_syn   <= '0;
         s1_par   <= 1'b0;
      end else begin
         if (s_ready) begin
            s1_valid <= s_valid;
         end
         if (accept) begin
            s1_word <= s_word[ENCODED_WORD:1];
            s1_syn  <= calc_syndrome(s_word[ENCODED_WORD:1]);
            s1_par  <= calc_parity(s_word);
         end
      end
   end

   // Stage 2: registered result, held while downstream stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         m_valid  <= 1'b0;
         data     <= '0;
         sec      <= 1'b0;
         ded      <= 1'b0;
         syndrome <= '0;
      end else if (s2_adv) begin
         m_valid <= s1_valid;
         if (s1_valid) begin
            data     <= next_data;
            sec      <= next_sec;
            ded      <= next_ded;
            syndrome <= s1_syn;
         end
      end
   end

   // Saturating event counters; a clear wins over a same-cycle increment.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sec_cnt <= '0;
         ded_cnt <= '0;
      end else if (clr_cnt) begin
         sec_cnt <= '0;
         ded_cnt <= '0;
      end else begin
         if (s2_load && next_sec && (sec_cnt != {CNT_W{1'b1}})) begin
            sec_cnt <= sec_cnt + CNT_W'(1);
         end
         if (s2_load && next_ded && (ded_cnt != {CNT_W{1'b1}})) begin
            ded_cnt <= ded_cnt + CNT_W'(1);
         end
      end
   end

endmodule

module ham_dec #(
   parameter int DATA_WIDTH   = 32,
   parameter int ENCODED_WORD = 38,
   parameter int SYN_W        = 6,
   parameter int CNT_W        = 16
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_clr_cnt,
   input  logic                    i_valid_a,
   output logic                    o_ready_a,
   input  logic [ENCODED_WORD+1:1] i_hamming_a,
   output logic                    o_valid_a,
   input  logic                    i_ready_a,
   output logic [DATA_WIDTH-1:0]   o_data_a,
   output logic                    o_sec_a,
   output logic                    o_ded_a,
   output logic [SYN_W-1:0]        o_syndrome_a,
   output logic [CNT_W-1:0]        o_sec_cnt_a,
   output logic [CNT_W-1:0]        o_ded_cnt_a,
   input  logic                    i_valid_b,
   output logic                    o_ready_b,
   input  logic [ENCODED_WORD+1:1] i_hamming_b,
   output logic                    o_valid_b,
   input  logic                    i_ready_b,
   output logic [DATA_WIDTH-1:0]   o_data_b,
   output logic                    o_sec_b,
   output logic                    o_ded_b,
   output logic [SYN_W-1:0]        o_syndrome_b,
   output logic [CNT_W-1:0]        o_sec_cnt_b,
   output logic [CNT_W-1:0]        o_ded_cnt_b
);

   ham_dec_port #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ENCODED_WORD (ENCODED_WORD),
      .SYN_W        (SYN_W),
      .CNT_W        (CNT_W)
   ) u_port_a (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .clr_cnt  (i_clr_cnt),
      .s_valid  (i_valid_a),
      .s_ready  (o_ready_a),
      .s_word   (i_hamming_a),
      .m_valid  (o_valid_a),
      .m_ready  (i_ready_a),
      .data     (o_data_a),
      .sec      (o_sec_a),
      .ded      (o_ded_a),
      .syndrome (o_syndrome_a),
      .sec_cnt  (o_sec_cnt_a),
      .ded_cnt  (o_ded_cnt_a)
   );

   ham_dec_port #(
      .DATA_WIDTH   (DATA_WIDTH),
      .ENCODED_WORD (ENCODED_WORD),
      .SYN_W        (SYN_W),
      .CNT_W        (CNT_W)
   ) u_port_b (
      .clk      (i_clk),
      .rst_n    (i_rst_n),
      .clr_cnt  (i_clr_cnt),
      .s_valid  (i_valid_b),
      .s_ready  (o_ready_b),
      .s_word   (i_hamming_b),
      .m_valid  (o_valid_b),
      .m_ready  (i_ready_b),
      .data     (o_data_b),
      .sec      (o_sec_b),
      .ded      (o_ded_b),
      .syndrome (o_syndrome_b),
      .sec_cnt  (o_sec_cnt_b),
      .ded_cnt  (o_ded_cnt_b)
   );

endmodule

// File: tb/tb_ham_dec.sv
// Self-checking bench for ham_dec: directed vector table per port,
// scoreboard-checked streaming with backpressure, counter saturation,
// counter clear and mid-stream reset.

module tb_ham_dec;

   typedef struct packed {
      logic [31:0] data;
      logic        sec;
      logic        ded;
      logic [5:0]  syn;
   } exp_t;

   typedef struct packed {
      logic [39:1] cw;
      exp_t        e;
      logic [15:0] sc;
      logic [15:0] dc;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        clr_cnt;
   logic        valid_a, valid_b;
   logic        ready_a, ready_b;
   logic [39:1] ham_a, ham_b;
   logic        out_valid_a, out_valid_b;
   logic        out_ready_a, out_ready_b;
   logic [31:0] data_a, data_b;
   logic        sec_a, sec_b, ded_a, ded_b;
   logic [5:0]  syn_a, syn_b;
   logic [15:0] sec_cnt_a, sec_cnt_b, ded_cnt_a, ded_cnt_b;

   exp_t q_a[$];
   exp_t q_b[$];
   int   n_cmp;
   int   n_err;
   int   cyc;

   ham_dec dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_clr_cnt    (clr_cnt),
      .i_valid_a    (valid_a),
      .o_ready_a    (ready_a),
      .i_hamming_a  (ham_a),
      .o_valid_a    (out_valid_a),
      .i_ready_a    (out_ready_a),
      .o_data_a     (data_a),
      .o_sec_a      (sec_a),
      .o_ded_a      (ded_a),
      .o_syndrome_a (syn_a),
      .o_sec_cnt_a  (sec_cnt_a),
      .o_ded_cnt_a  (ded_cnt_a),
      .i_valid_b    (valid_b),
      .o_ready_b    (ready_b),
      .i_hamming_b  (ham_b),
      .o_valid_b    (out_valid_b),
      .i_ready_b    (out_ready_b),
      .o_data_b     (data_b),
      .o_sec_b      (sec_b),
      .o_ded_b      (ded_b),
      .o_syndrome_b (syn_b),
      .o_sec_cnt_b  (sec_cnt_b),
      .o_ded_cnt_b  (ded_cnt_b)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Reference encoder: data into non-power-of-2 positions, even parity, overall bit 39.
   function automatic logic [39:1] enc(input logic [31:0] d);
      logic [39:1] w;
      logic [39:1] t;
      logic [31:0] dd;
      logic        p;
      w  = '0;
      dd = d;
      for (int k = 1; k <= 38; k++) begin
         if ((k & (k - 1)) != 0) begin
            w  = w | (39'(dd[0]) << (k - 1));
            dd = dd >> 1;
         end
      end
      for (int i = 0; i < 6; i++) begin
         p = 1'b0;
         for (int k = 1; k <= 38; k++) begin
            t = w >> (k - 1);
            if ((((k >> i) & 1) != 0) && (k != (1 << i))) p = p ^ t[1];
         end
         w = w | (39'(p) << ((1 << i) - 1));
      end
      w[39] = ^w[38:1];
      return w;
   endfunction

   function automatic vec_t mk(input logic [39:1] cw, input logic [31:0] d, input logic s,
                               input logic dd, input logic [5:0] sy, input logic [15:0] sc,
                               input logic [15:0] dc);
      vec_t v;
      v.cw = cw; v.e.data = d; v.e.sec = s; v.e.ded = dd; v.e.syn = sy; v.sc = sc; v.dc = dc;
      return v;
   endfunction

   // Present one word on port p until accepted; push its expected result on accept.
   task automatic drive(input int p, input logic [39:1] cw, input exp_t e);
      bit done;
      done = 1'b0;
      if (p == 0) begin valid_a = 1'b1; ham_a = cw; end
      else        begin valid_b = 1'b1; ham_b = cw; end
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         if ((p == 0 && ready_a) || (p == 1 && ready_b)) begin
            if (p == 0) q_a.push_back(e); else q_b.push_back(e);
            done = 1'b1;
         end
         @(posedge clk); #1;
      end
      if (!done) check("drive_timeout", 64'd0, 64'd1);
      if (p == 0) valid_a = 1'b0; else valid_b = 1'b0;
   endtask

   // Scoreboard and hold monitor, sampling on the falling edge.
   task automatic monitor();
      exp_t        e;
      logic        stall_a, stall_b;
      logic [39:0] held_a, held_b;
      stall_a = 1'b0;
      stall_b = 1'b0;
      held_a  = '0;
      held_b  = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst_n) begin
            if (stall_a) begin
               check("hold_valid_a", out_valid_a, 1);
               check("hold_a", {data_a, sec_a, ded_a, syn_a}, held_a);
            end
            if (out_valid_a && out_ready_a) begin
               if (q_a.size() == 0) check("unexpected_a", out_valid_a, 0);
               else begin
                  e = q_a.pop_front();
                  check("data_a", data_a, e.data);
                  check("sec_a", sec_a, e.sec);
                  check("ded_a", ded_a, e.ded);
                  check("syn_a", syn_a, e.syn);
               end
            end
            stall_a = out_valid_a && !out_ready_a;
            held_a  = {data_a, sec_a, ded_a, syn_a};
            if (stall_b) begin
               check("hold_valid_b", out_valid_b, 1);
               check("hold_b", {data_b, sec_b, ded_b, syn_b}, held_b);
            end
            if (out_valid_b && out_ready_b) begin
               if (q_b.size() == 0) check("unexpected_b", out_valid_b, 0);
               else begin
                  e = q_b.pop_front();
                  check("data_b", data_b, e.data);
                  check("sec_b", sec_b, e.sec);
                  check("ded_b", ded_b, e.ded);
                  check("syn_b", syn_b, e.syn);
               end
            end
            stall_b = out_valid_b && !out_ready_b;
            held_b  = {data_b, sec_b, ded_b, syn_b};
         end else begin
            stall_a = 1'b0;
            stall_b = 1'b0;
         end
      end
   endtask

   task automatic wait_drain();
      for (int t = 0; t < 200 && (q_a.size() + q_b.size()) != 0; t++) @(posedge clk);
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic stream_port(input int p, input int n, output int nsec);
      logic [31:0] d;
      logic [39:1] cw;
      int          fl;
      exp_t        e;
      nsec = 0;
      for (int i = 0; i < n; i++) begin
         d  = $urandom;
         fl = $urandom_range(0, 39);
         cw = enc(d);
         if (fl != 0) begin
            cw = cw ^ (39'(1) << (fl - 1));
            nsec++;
         end
         e.data = d;
         e.sec  = (fl != 0);
         e.ded  = 1'b0;
         e.syn  = (fl == 0 || fl == 39) ? 6'd0 : 6'(fl);
         drive(p, cw, e);
      end
   endtask

   task automatic toggle_b(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         out_ready_b = !out_ready_b;
      end
      out_ready_b = 1'b1;
   endtask

   vec_t tbl[10];
   int   t0;
   int   ns_a, ns_b;
   int   base;
   exp_t e3;

   // Main test sequence.
   initial begin
      n_cmp = 0; n_err = 0; cyc = 0;
      rst_n = 1'b0; clr_cnt = 1'b0;
      valid_a = 1'b0; valid_b = 1'b0; ham_a = '0; ham_b = '0;
      out_ready_a = 1'b1; out_ready_b = 1'b1;
      fork monitor(); join_none

      tbl[0] = mk(39'h0,             32'h0,        1'b0, 1'b0, 6'd0,  16'd0, 16'd0);
      tbl[1] = mk(39'h4,             32'h0,        1'b1, 1'b0, 6'd3,  16'd1, 16'd0);
      tbl[2] = mk(39'h10,            32'h0,        1'b1, 1'b0, 6'd5,  16'd2, 16'd0);
      tbl[3] = mk(39'h14,            32'h3,        1'b0, 1'b1, 6'd6,  16'd2, 16'd1);
      tbl[4] = mk(39'h40_0000_0000,  32'h0,        1'b1, 1'b0, 6'd0,  16'd3, 16'd1);
      tbl[5] = mk(39'h40_8000_0040,  32'h8,        1'b0, 1'b1, 6'd39, 16'd3, 16'd2);
      tbl[6] = mk(enc(32'hDEADBEEF), 32'hDEADBEEF, 1'b0, 1'b0, 6'd0,  16'd3, 16'd2);
      tbl[7] = mk(enc(32'hDEADBEEF) ^ (39'(1) << 37), 32'hDEADBEEF, 1'b1, 1'b0, 6'd38, 16'd4, 16'd2);
      tbl[8] = mk(enc(32'hA5A5A5A5) ^ 39'h1, 32'hA5A5A5A5, 1'b1, 1'b0, 6'd1, 16'd5, 16'd2);
      tbl[9] = mk(enc(32'h12345678) ^ 39'h300, 32'h12345648, 1'b0, 1'b1, 6'd3, 16'd5, 16'd3);

      repeat (3) @(posedge clk);
      #1;
      check("rst_valid_a", out_valid_a, 0);
      check("rst_valid_b", out_valid_b, 0);
      check("rst_data_a", data_a, 0);
      check("rst_flags_b", {sec_b, ded_b, syn_b}, 0);
      check("rst_cnt_a", {sec_cnt_a, ded_cnt_a}, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int p = 0; p < 2; p++) begin
         for (int i = 0; i < 10; i++) begin
            drive(p, tbl[i].cw, tbl[i].e);
            check("lat_s1", (p == 0) ? out_valid_a : out_valid_b, 0);
            @(posedge clk); #1;
            check("lat_s2", (p == 0) ? out_valid_a : out_valid_b, 1);
            check("sec_cnt", (p == 0) ? sec_cnt_a : sec_cnt_b, tbl[i].sc);
            check("ded_cnt", (p == 0) ? ded_cnt_a : ded_cnt_b, tbl[i].dc);
            @(posedge clk); #1;
         end
      end

      fork
         begin
            t0 = cyc;
            stream_port(0, 8, ns_a);
            check("thru_a", cyc - t0, 8);
         end
         stream_port(1, 8, ns_b);
         toggle_b(40);
      join
      wait_drain();
      check("stream_q_a", q_a.size(), 0);
      check("stream_q_b", q_b.size(), 0);
      check("stream_cnt_b", sec_cnt_b, 5 + ns_b);

      e3.data = 32'h0; e3.sec = 1'b1; e3.ded = 1'b0; e3.syn = 6'd3;
      base = 5 + ns_a;
      check("pre_sat_a", sec_cnt_a, base);
      for (int i = 0; i < 65535 - base; i++) drive(0, 39'h4, e3);
      wait_drain();
      check("sat_reach_a", sec_cnt_a, 16'hFFFF);
      for (int i = 0; i < 3; i++) drive(0, 39'h4, e3);
      wait_drain();
      check("sat_hold_a", sec_cnt_a, 16'hFFFF);

      drive(0, 39'h4, e3);
      clr_cnt = 1'b1;
      @(posedge clk); #1;
      clr_cnt = 1'b0;
      check("clr_valid_a", out_valid_a, 1);
      check("clr_sec_a", sec_cnt_a, 0);
      check("clr_ded_a", ded_cnt_a, 0);
      check("clr_sec_b", sec_cnt_b, 0);
      check("clr_ded_b", ded_cnt_b, 0);
      @(posedge clk); #1;
      check("clr_after_a", sec_cnt_a, 0);
      wait_drain();

      valid_a = 1'b1; ham_a = 39'h4;
      @(posedge clk); #1;
      ham_a = 39'h10;
      @(posedge clk); #1;
      valid_a = 1'b0;
      check("inflight_a", out_valid_a, 1);
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst_valid_a", out_valid_a, 0);
      check("midrst_valid_b", out_valid_b, 0);
      check("midrst_out_a", {data_a, sec_a, ded_a, syn_a}, 0);
      check("midrst_cnt_a", sec_cnt_a, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("post_rst_valid_a", out_valid_a, 0);
      end
      check("final_q", q_a.size() + q_b.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ham_dec.md
Name: ham_dec

Overview:
- Dual-port pipelined SECDED Hamming decoder; receiver side of the ham_enc encoded-word format.
- Sits on the read path of the dual-port memory (ports a/b): takes stored encoded words, checks them, corrects single-bit errors, detects double-bit errors and returns data words.
- Each port has its own valid/ready streaming handshake, a 2-stage pipeline and saturating error counters.

Parameters:
- DATA_WIDTH, 32, data bits per word.
- ENCODED_WORD, 38, Hamming word length excluding the overall-parity bit; must satisfy 2^P >= DATA_WIDTH+P+1.
- SYN_W, 6, syndrome width = clog2(ENCODED_WORD+1).
- CNT_W, 16, error counter width.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_clr_cnt  in  1  synchronous clear of all four error counters
- i_valid_a / i_valid_b  in  1  encoded word valid
- o_ready_a / o_ready_b  out  1  decoder can accept a word
- i_hamming_a / i_hamming_b  in  [ENCODED_WORD+1:1]  encoded word; bit ENCODED_WORD+1 is overall parity
- o_valid_a / o_valid_b  out  1  decoded result valid
- i_ready_a / i_ready_b  in  1  downstream accepts result
- o_data_a / o_data_b  out  DATA_WIDTH  decoded (corrected when possible) data
- o_sec_a / o_sec_b  out  1  single error corrected
- o_ded_a / o_ded_b  out  1  uncorrectable error detected
- o_syndrome_a / o_syndrome_b  out  SYN_W  registered syndrome
- o_sec_cnt_a / o_sec_cnt_b  out  CNT_W  saturating count of sec events
- o_ded_cnt_a / o_ded_cnt_b  out  CNT_W  saturating count of ded events

Behaviour:
- Clock and reset: one clock, i_clk. Reset is synchronous and active-low (i_rst_n).
- Reset values: all valids, flags, syndromes, data outputs and counters are 0. Reset mid-stream drops all in-flight words; no output is produced for them.
- Ports a and b are fully independent and identical. Everything below is per port.
- Word format, indices 1..ENCODED_WORD:
  - Parity bits sit at power-of-2 positions.
  - Data bits fill the non-power-of-2 positions in ascending order: position 3 = data[0], 5 = data[1], 6 = data[2], 7 = data[3], 9 = data[4], ..., highest = data[DATA_WIDTH-1].
  - Encoding is even parity.
  - Bit ENCODED_WORD+1 = XOR of bits [ENCODED_WORD:1].
- Stage 1 (on accept: i_valid && o_ready):
  - Register the codeword.
  - S = XOR of index k over all k in 1..ENCODED_WORD with bit k set.
  - P = XOR of all ENCODED_WORD+1 bits.
- Stage 2 classification:
  - S=0, P=0: clean. Data extracted unchanged; sec=0, ded=0.
  - S in 1..ENCODED_WORD, P=1: flip bit S, then extract; sec=1. A parity-position flip leaves data unchanged.
  - S=0, P=1: overall-parity bit error. Data unchanged; sec=1.
  - S!=0, P=0: double error. Raw uncorrected data; ded=1.
  - S>ENCODED_WORD, P=1: uncorrectable. Raw data; ded=1.
  - sec and ded are never both 1. o_syndrome = S in every case.
- Latency: exactly 2 cycles from accept to o_valid when there is no backpressure. Throughput 1 word/cycle.
- Handshake:
  - s2_adv = !o_valid || i_ready.
  - o_ready = !s1_valid || s2_adv (combinational).
  - Outputs are held stable while o_valid && !i_ready.
  - No word is dropped or duplicated. Order is preserved.
  - Accept and output in the same cycle is allowed.
- Counters:
  - Increment once per word at the stage-2 load, according to its flag.
  - Saturate at 2^CNT_W-1.
  - i_clr_cnt has priority over a simultaneous increment (result 0).
  - i_clr_cnt does not affect the pipeline.

Test Plan:
- Encoded word all-zero on port a -> 2 cycles later o_valid_a=1, o_data_a=0, sec=0, ded=0, syndrome=0.
- Zero codeword with bit 3 flipped -> o_data_a=0, o_sec_a=1, syndrome=3, o_sec_cnt_a=1. Repeat with bit 5 -> syndrome=5, count=2.
- Zero codeword with bits 3 and 5 flipped -> o_ded_a=1, syndrome=6, o_data_a=0x00000003 (uncorrected), o_ded_cnt_a=1.
- Zero codeword with only bit 39 flipped -> sec=1, syndrome=0, data=0. With bits 32, 7 and 39 flipped -> syndrome=39 > 38, ded=1.
- Stream 8 back-to-back words on both ports with i_ready_b toggling every cycle -> port a completes at 1/cycle; port b outputs stay held while stalled; both ports deliver all 8 words in order with no loss.
- Counters preset near max via 2^CNT_W sec events -> count stays 0xFFFF. Assert i_clr_cnt together with a sec result -> count 0. Assert i_rst_n=0 with 2 words in flight -> next cycle o_valid=0, no outputs for those words.
